// File: rtl/light_decoder_pkg.sv
// ---------------------------------------------------------------------------
// light_decoder_pkg
// Shared definitions for the optical-link receiver: default frame geometry,
// the receiver FSM state encoding and a counter-width helper.
// ---------------------------------------------------------------------------
package light_decoder_pkg;

   // Default frame geometry: data bits per frame and clocks per line symbol.
   localparam int PACKET_SIZE = 8;
   localparam int BIT_CYCLES  = 4;

   // Receiver FSM states (2-bit encoding).
   typedef enum logic [1:0] {
      DEC_IDLE  = 2'd0,
      DEC_START = 2'd1,
      DEC_DATA  = 2'd2,
      DEC_STOP  = 2'd3
   } dec_state_t;

   // Width needed to count 0..value-1, never less than one bit.
   function automatic int min1_clog2(input int value);
      int w;
      w = $clog2(value);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/light_decoder_input_synchronizer.sv
// ---------------------------------------------------------------------------
// input_synchronizer
// Two-flop synchroniser that brings one asynchronous pin into the clock
// domain. Reusable for any asynchronous 1-bit input.
// Ports:
//   i_clock   : system clock, rising edge
//   i_reset_n : asynchronous active-low reset, clears both flops
//   i_async   : raw asynchronous input
//   o_sync    : synchronised copy, two clocks of latency
// ---------------------------------------------------------------------------
module input_synchronizer (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture; r_meta may go metastable and is never used elsewhere.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/light_decoder.sv
// ---------------------------------------------------------------------------
// light_decoder
// Receive side of the optical link. Synchronises the photodiode bit, detects
// the start edge, samples PACKET_SIZE data bits MSB-first at mid-bit, checks
// the stop bit and presents good packets with a one-cycle valid strobe.
// Line format: idle=0, start=1, data MSB first, stop=0, BIT_CYCLES clocks each.
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   enable      : receiver enable; low aborts any frame and holds IDLE
//   sensor      : raw photodiode bit, asynchronous to clock
//   data        : last good packet, held until the next good frame
//   valid       : one-cycle strobe, data updated in the same cycle
//   frame_error : one-cycle strobe, stop bit read as 1
//   busy        : high whenever the receiver is not IDLE
// ---------------------------------------------------------------------------
module light_decoder
   import light_decoder_pkg::*;
#(
   parameter int P_PACKET_SIZE = PACKET_SIZE,
   parameter int P_BIT_CYCLES  = BIT_CYCLES
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     sensor,
   output logic [P_PACKET_SIZE-1:0] data,
   output logic                     valid,
   output logic                     frame_error,
   output logic                     busy
);

   localparam int CYC_W = min1_clog2(P_BIT_CYCLES);
   localparam int BIT_W = min1_clog2(P_PACKET_SIZE);

   // Start bit is re-checked half a symbol in; data/stop use the full symbol.
   localparam logic [CYC_W-1:0] CYC_HALF_LAST = CYC_W'(P_BIT_CYCLES / 2 - 1);
   localparam logic [CYC_W-1:0] CYC_LAST      = CYC_W'(P_BIT_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(P_PACKET_SIZE - 1);

   logic                     w_s;
   logic                     r_s_prev;
   dec_state_t               r_state;
   dec_state_t               w_state_next;
   logic [CYC_W-1:0]         r_cyc;
   logic [CYC_W-1:0]         w_cyc_next;
   logic [BIT_W-1:0]         r_bit_idx;
   logic [BIT_W-1:0]         w_bit_next;
   logic [P_PACKET_SIZE-1:0] r_shift;
   logic [P_PACKET_SIZE-1:0] w_shift_next;
   logic [P_PACKET_SIZE:0]   w_shift_cat;
   logic [P_PACKET_SIZE-1:0] r_data;
   logic [P_PACKET_SIZE-1:0] w_data_next;
   logic                     r_valid;
   logic                     w_valid_next;
   logic                     r_frame_error;
   logic                     w_frame_error_next;
   logic                     r_busy;

   input_synchronizer u_sensor_sync (
      .i_clock   (clock),
      .i_reset_n (reset),
      .i_async   (sensor),
      .o_sync    (w_s)
   );

   // Shifting in the synchronised bit; the top bit falls off.
   assign w_shift_cat = {r_shift, w_s};

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= DEC_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, counter, shift and strobe decode.
   always_comb begin
      w_state_next       = r_state;
      w_cyc_next         = r_cyc + CYC_W'(1);
      w_bit_next         = r_bit_idx;
      w_shift_next       = r_shift;
      w_data_next        = r_data;
      w_valid_next       = 1'b0;
      w_frame_error_next = 1'b0;

      if (!enable) begin
         w_state_next = DEC_IDLE;
         w_cyc_next   = '0;
         w_bit_next   = '0;
      end else begin
         case (r_state)
            DEC_IDLE: begin
               w_cyc_next = '0;
               w_bit_next = '0;
               // Rising edge only: a line stuck high never restarts a frame.
               if (w_s && !r_s_prev) begin
                  w_state_next = DEC_START;
               end else begin
                  w_state_next = DEC_IDLE;
               end
            end
            DEC_START: begin
               if (r_cyc == CYC_HALF_LAST) begin
                  w_cyc_next = '0;
                  w_bit_next = '0;
                  // Start bit gone at mid-symbol means it was a glitch.
                  if (w_s) begin
                     w_state_next = DEC_DATA;
                  end else begin
                     w_state_next = DEC_IDLE;
                  end
               end else begin
                  w_state_next = DEC_START;
               end
            end
            DEC_DATA: begin
               if (r_cyc == CYC_LAST) begin
                  w_cyc_next   = '0;
                  w_shift_next = w_shift_cat[P_PACKET_SIZE-1:0];
                  if (r_bit_idx == BIT_LAST) begin
                     w_bit_next   = '0;
                     w_state_next = DEC_STOP;
                  end else begin
                     w_bit_next   = r_bit_idx + BIT_W'(1);
                     w_state_next = DEC_DATA;
                  end
               end else begin
                  w_state_next = DEC_DATA;
               end
            end
            DEC_STOP: begin
               if (r_cyc == CYC_LAST) begin
                  w_cyc_next   = '0;
                  w_bit_next   = '0;
                  w_state_next = DEC_IDLE;
                  if (!w_s) begin
                     w_data_next  = r_shift;
                     w_valid_next = 1'b1;
                  end else begin
                     w_frame_error_next = 1'b1;
                  end
               end else begin
                  w_state_next = DEC_STOP;
               end
            end
            default: begin
               w_state_next = DEC_IDLE;
               w_cyc_next   = '0;
               w_bit_next   = '0;
            end
         endcase
      end
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_s_prev      <= 1'b0;
         r_cyc         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_data        <= '0;
         r_valid       <= 1'b0;
         r_frame_error <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_s_prev      <= w_s;
         r_cyc         <= w_cyc_next;
         r_bit_idx     <= w_bit_next;
         r_shift       <= w_shift_next;
         r_data        <= w_data_next;
         r_valid       <= w_valid_next;
         r_frame_error <= w_frame_error_next;
         r_busy        <= (w_state_next != DEC_IDLE);
      end
   end

   assign data        = r_data;
   assign valid       = r_valid;
   assign frame_error = r_frame_error;
   assign busy        = r_busy;

endmodule
